// File: rtl/db15_pkg.sv
// Shared types and constants for the DB15 joystick serial reader.
// Bit-index constants follow the player word map LS FEDCBAUDLR with bit 0 = R.
package db15_pkg;

  localparam int DB15_BITS        = 32;
  localparam int DB15_PLAYER_BITS = 16;

  localparam int DB15_BIT_R     = 0;
  localparam int DB15_BIT_L     = 1;
  localparam int DB15_BIT_DOWN  = 2;
  localparam int DB15_BIT_U     = 3;
  localparam int DB15_BIT_A     = 4;
  localparam int DB15_BIT_B     = 5;
  localparam int DB15_BIT_C     = 6;
  localparam int DB15_BIT_BTN_D = 7;
  localparam int DB15_BIT_E     = 8;
  localparam int DB15_BIT_F     = 9;
  localparam int DB15_BIT_S     = 10;
  localparam int DB15_BIT_SPARE = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_GAP
  } db15_state_e;

endpackage

// File: rtl/db15_serial_reader_if.sv
// Adapter pins plus published player words; master is the reader, slave is the
// adapter/consumer side.
interface db15_serial_reader_if import db15_pkg::*; ();

  logic                        JOY_DATA;
  logic                        JOY_CLK;
  logic                        JOY_LOAD;
  logic [DB15_PLAYER_BITS-1:0] joystick1;
  logic [DB15_PLAYER_BITS-1:0] joystick2;
  logic                        frame_valid;

  modport master (
    input  JOY_DATA,
    output JOY_CLK,
    output JOY_LOAD,
    output joystick1,
    output joystick2,
    output frame_valid
  );

  modport slave (
    output JOY_DATA,
    input  JOY_CLK,
    input  JOY_LOAD,
    input  joystick1,
    input  joystick2,
    input  frame_valid
  );

endinterface

// File: rtl/db15_tick_gen.sv
// Free-running divider producing a one-clk tick every DIV clocks; each tick
// marks one half-period of the adapter shift clock.
module db15_tick_gen #(
  parameter int DIV = 24
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == CW'(DIV - 1)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CW'(DIV - 1));

endmodule

// File: rtl/db15_serial_reader.sv
// DB15 UserIO serial front-end: loads the adapter, shifts 32 bits, publishes two
// active-high player words. Optional frame debounce via DB15_DEBOUNCE_EN.
module db15_serial_reader import db15_pkg::*; #(
  parameter int DIV       = 24,
  parameter int GAP_TICKS = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  db15_serial_reader_if.master  bus
);

  logic tick;

  db15_tick_gen #(.DIV(DIV)) tickGen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  db15_state_e                 state_q, state_d;
  logic                        syncMeta_q, dataS_q;
  logic [4:0]                  bitcnt_q, bitcnt_d;
  logic                        loadCnt_q, loadCnt_d;
  logic [15:0]                 gapCnt_q, gapCnt_d;
  logic [DB15_BITS-1:0]        sr_q, sr_d;
  logic                        joyClk_q, joyClk_d;
  logic                        joyLoad_q, joyLoad_d;
  logic [DB15_PLAYER_BITS-1:0] joy1_q, joy1_d;
  logic [DB15_PLAYER_BITS-1:0] joy2_q, joy2_d;
  logic                        fv_q, fv_d;
  logic                        publish;
`ifdef DB15_DEBOUNCE_EN
  logic [DB15_BITS-1:0]        cand_q, cand_d;
  logic                        candValid_q, candValid_d;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    loadCnt_d = loadCnt_q;
    gapCnt_d  = gapCnt_q;
    sr_d      = sr_q;
    joyClk_d  = joyClk_q;
    joyLoad_d = joyLoad_q;
    publish   = 1'b0;
`ifdef DB15_DEBOUNCE_EN
    cand_d      = cand_q;
    candValid_d = candValid_q;
`endif
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_LOAD;
          joyLoad_d = 1'b0;
          loadCnt_d = 1'b0;
        end
        ST_LOAD: begin
          if (loadCnt_q) begin
            state_d   = ST_SHIFT_LO;
            joyLoad_d = 1'b1;
            bitcnt_d  = '0;
          end else begin
            loadCnt_d = 1'b1;
          end
        end
        ST_SHIFT_LO: begin
          sr_d[bitcnt_q] = dataS_q;
          joyClk_d       = 1'b1;
          state_d        = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          joyClk_d = 1'b0;
          if (bitcnt_q == 5'd31) begin
            state_d  = ST_GAP;
            gapCnt_d = '0;
`ifdef DB15_DEBOUNCE_EN
            // Only a frame identical to the held candidate is trusted.
            publish     = candValid_q && (cand_q == sr_q);
            cand_d      = sr_q;
            candValid_d = 1'b1;
`else
            publish = 1'b1;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
            state_d  = ST_SHIFT_LO;
          end
        end
        ST_GAP: begin
          if (gapCnt_q == 16'(GAP_TICKS - 1)) begin
            state_d   = ST_LOAD;
            joyLoad_d = 1'b0;
            loadCnt_d = 1'b0;
          end else begin
            gapCnt_d = gapCnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Buttons are active-low on the wire; both words load in the same edge.
  always_comb begin
    joy1_d = joy1_q;
    joy2_d = joy2_q;
    fv_d   = 1'b0;
    if (publish) begin
      joy1_d = ~sr_q[DB15_PLAYER_BITS-1:0];
      joy2_d = ~sr_q[DB15_BITS-1:DB15_PLAYER_BITS];
      fv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      syncMeta_q  <= 1'b0;
      dataS_q     <= 1'b0;
      bitcnt_q    <= '0;
      loadCnt_q   <= 1'b0;
      gapCnt_q    <= '0;
      sr_q        <= '0;
      joyClk_q    <= 1'b0;
      joyLoad_q   <= 1'b1;
      joy1_q      <= '0;
      joy2_q      <= '0;
      fv_q        <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
      cand_q      <= '0;
      candValid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      syncMeta_q  <= bus.JOY_DATA;
      dataS_q     <= syncMeta_q;
      bitcnt_q    <= bitcnt_d;
      loadCnt_q   <= loadCnt_d;
      gapCnt_q    <= gapCnt_d;
      sr_q        <= sr_d;
      joyClk_q    <= joyClk_d;
      joyLoad_q   <= joyLoad_d;
      joy1_q      <= joy1_d;
      joy2_q      <= joy2_d;
      fv_q        <= fv_d;
`ifdef DB15_DEBOUNCE_EN
      cand_q      <= cand_d;
      candValid_q <= candValid_d;
`endif
    end
  end

  assign bus.JOY_CLK     = joyClk_q;
  assign bus.JOY_LOAD    = joyLoad_q;
  assign bus.joystick1   = joy1_q;
  assign bus.joystick2   = joy2_q;
  assign bus.frame_valid = fv_q;

endmodule

// File: tb/tb_db15_serial_reader.sv
// Self-checking bench for db15_serial_reader with an adapter model and a
// frame-level reference model (DB15_DEBOUNCE_EN selects the debounce rules).
module tb_db15_serial_reader;
  import db15_pkg::*;

  localparam int TB_DIV     = 4;
  localparam int TB_GAP     = 4;
  localparam int CLK_HALF   = 5;
  localparam int FRAME_CLKS = (2 + 64 + TB_GAP) * TB_DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  db15_serial_reader_if joyIf ();

  db15_serial_reader #(.DIV(TB_DIV), .GAP_TICKS(TB_GAP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (joyIf)
  );

  always #CLK_HALF clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Adapter model: parallel-load on JOY_LOAD fall, advance one bit per JOY_CLK rise.
  logic [31:0] pattern = 32'hFFFF_FFFF;
  logic [31:0] patQ[$];
  logic [31:0] loaded  = 32'hFFFF_FFFF;
  int          bitIdx  = 32;
  int          loadCnt = 0;
  bit          asyncJitter = 1'b0;

  initial joyIf.JOY_DATA = 1'b1;

  always @(negedge joyIf.JOY_LOAD) begin
    if (patQ.size() > 0) loaded = patQ.pop_front();
    else                 loaded = pattern;
    bitIdx = 0;
    loadCnt++;
    joyIf.JOY_DATA = loaded[0];
  end

  always @(posedge joyIf.JOY_CLK) begin
    int d;
    d = asyncJitter ? int'($urandom_range(1, 35)) : 1;
    #(d);
    bitIdx++;
    joyIf.JOY_DATA = (bitIdx < 32) ? loaded[bitIdx] : 1'b1;
  end

  // Waveform monitor and frame-level reference model.
  int riseCnt = 0, lastRises = 0, loadLowCnt = 0, lastLoadLow = 0;
  int clkHighInLoad = 0, fvWide = 0, fvCnt = 0, modelPubCnt = 0;
  int cyc = 0, lastFvCyc = 0, lastFvGap = 0;
  logic prevClk = 1'b0, prevLoad = 1'b1, prevFv = 1'b0;
  logic [31:0] prevFrame = '0;
  bit prevValid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      riseCnt    = 0;
      loadLowCnt = 0;
      prevValid  = 1'b0;
    end else begin
      if (joyIf.JOY_LOAD === 1'b0) begin
        loadLowCnt++;
        if (joyIf.JOY_CLK === 1'b1) clkHighInLoad++;
      end
      if (prevLoad && joyIf.JOY_LOAD === 1'b0) begin
        lastRises = riseCnt;
        riseCnt   = 0;
      end
      if (!prevLoad && joyIf.JOY_LOAD === 1'b1) begin
        lastLoadLow = loadLowCnt;
        loadLowCnt  = 0;
      end
      if (!prevClk && joyIf.JOY_CLK === 1'b1) begin
        riseCnt++;
        if (riseCnt == 32) begin
`ifdef DB15_DEBOUNCE_EN
          if (prevValid && prevFrame == loaded) modelPubCnt++;
          prevFrame = loaded;
          prevValid = 1'b1;
`else
          modelPubCnt++;
`endif
        end
      end
    end
    if (joyIf.frame_valid === 1'b1) begin
      fvCnt++;
      if (prevFv) fvWide++;
      lastFvGap = cyc - lastFvCyc;
      lastFvCyc = cyc;
      checkOutput("fvJoy1", {16'h0, joyIf.joystick1}, {16'h0, ~loaded[15:0]});
      checkOutput("fvJoy2", {16'h0, joyIf.joystick2}, {16'h0, ~loaded[31:16]});
    end
    prevClk  = joyIf.JOY_CLK;
    prevLoad = joyIf.JOY_LOAD;
    prevFv   = joyIf.frame_valid;
  end

  task automatic waitFv(input string name);
    int base;
    bit seen;
    base = fvCnt;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CLKS * 4; i++) begin
      @(negedge clk);
      #1;
      if (fvCnt > base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout(name);
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input string name);
    int base;
    bit seen;
    pattern = frame;
    base = loadCnt;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CLKS * 2; i++) begin
      @(negedge clk);
      #1;
      if (loadCnt > base) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout({name, "Load"});
    else       waitFv(name);
  endtask

  typedef struct {
    logic [31:0] frame;
    logic [15:0] expJ1;
    logic [15:0] expJ2;
    string       tag;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [31:0] r;
    int loadBase;
    bit seen;

    vecs[0] = '{32'hFFFF_FFFF, 16'h0000, 16'h0000, "idlePad"};
    vecs[1] = '{32'hFBFF_FFF7, 16'h0008, 16'h0400, "singleBtn"};
    vecs[2] = '{32'h0000_0000, 16'hFFFF, 16'hFFFF, "allPressed"};
    vecs[3] = '{32'hA5A5_5A5A, 16'hA5A5, 16'h5A5A, "checker"};
    vecs[4] = '{32'h1234_FFFE, 16'h0001, 16'hEDCB, "mixed"};

    #2 reset_n = 1'b0;
    #10;
    checkOutput("rstJoyClk",  {31'h0, joyIf.JOY_CLK},     32'h0);
    checkOutput("rstJoyLoad", {31'h0, joyIf.JOY_LOAD},    32'h1);
    checkOutput("rstJoy1",    {16'h0, joyIf.joystick1},   32'h0);
    checkOutput("rstJoy2",    {16'h0, joyIf.joystick2},   32'h0);
    checkOutput("rstFv",      {31'h0, joyIf.frame_valid}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].frame, vecs[i].tag);
      checkOutput({vecs[i].tag, "J1"}, {16'h0, joyIf.joystick1}, {16'h0, vecs[i].expJ1});
      checkOutput({vecs[i].tag, "J2"}, {16'h0, joyIf.joystick2}, {16'h0, vecs[i].expJ2});
    end

    waitFv("steady1");
    waitFv("steady2");
    checkOutput("fvPeriod",      lastFvGap,     FRAME_CLKS);
    checkOutput("loadLowClks",   lastLoadLow,   2 * TB_DIV);
    checkOutput("clkRises",      lastRises,     32);
    checkOutput("clkHighInLoad", clkHighInLoad, 0);
    checkOutput("fvWidth",       fvWide,        0);

    asyncJitter = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      applyStimulus(r, "random");
      checkOutput("randJ1", {16'h0, joyIf.joystick1}, {16'h0, ~r[15:0]});
      checkOutput("randJ2", {16'h0, joyIf.joystick2}, {16'h0, ~r[31:16]});
    end
    asyncJitter = 1'b0;

    applyStimulus(32'h0000_0000, "preReset");
    seen = 1'b0;
    for (int i = 0; i < FRAME_CLKS * 2; i++) begin
      @(negedge clk);
      #1;
      if (riseCnt == 17) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) reportTimeout("bit17");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midRstJoy1",    {16'h0, joyIf.joystick1},   32'h0);
    checkOutput("midRstJoy2",    {16'h0, joyIf.joystick2},   32'h0);
    checkOutput("midRstJoyClk",  {31'h0, joyIf.JOY_CLK},     32'h0);
    checkOutput("midRstJoyLoad", {31'h0, joyIf.JOY_LOAD},    32'h1);
    checkOutput("midRstFv",      {31'h0, joyIf.frame_valid}, 32'h0);

    patQ.push_back(~32'h0000_0001);
    patQ.push_back(~32'h0000_0002);
    patQ.push_back(~32'h0000_0002);
    pattern  = ~32'h0000_0002;
    loadBase = loadCnt;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;

    waitFv("seqFirst");
`ifdef DB15_DEBOUNCE_EN
    checkOutput("seqFirstJ1",    {16'h0, joyIf.joystick1}, 32'h0002);
    checkOutput("seqFirstFrame", loadCnt - loadBase,       3);
`else
    checkOutput("seqFirstJ1",    {16'h0, joyIf.joystick1}, 32'h0001);
    checkOutput("seqFirstFrame", loadCnt - loadBase,       1);
`endif
    checkOutput("seqFirstJ2", {16'h0, joyIf.joystick2}, 32'h0);
    waitFv("seqNext");
    checkOutput("seqNextJ1", {16'h0, joyIf.joystick1}, 32'h0002);
    checkOutput("pubCount", fvCnt, modelPubCnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
